chr_pixel_pipe: RTL and testbench
=================================

CHR_PIXEL_PIPE -- requirements
Module: chr_pixel_pipe

Interface
REQ-001 SHALL have parameters (name, default, meaning): GLYPH_W 8 glyph width in pixels; GLYPH_H 16 glyph height in rows; FIRST_CHR 32 code of glyph index 0; NUM_GLYPHS 96 glyphs in ROM; COLOR_W 4 colour index width; BLINK_DIV 32 frame_tick count per cursor phase.
REQ-002 SHALL derive COL_W=$clog2(GLYPH_W), ROW_W=$clog2(GLYPH_H), ADDR_W=$clog2(NUM_GLYPHS*GLYPH_H).
REQ-003 Ports (name  direction  width  meaning): clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  pixel request this cycle; chr_val  in  8  character code; attr  in  2*COLOR_W  [COLOR_W-1:0]=fg, upper=bg; col  in  COL_W  pixel column in glyph; row  in  ROW_W  glyph row; cursor_hit  in  1  request lies in cursor cell.
REQ-005 frame_tick  in  1  one-cycle pulse per video frame.
REQ-006 rom_addr  out  ADDR_W  glyph ROM address; rom_q  in  GLYPH_W  ROM data, one-cycle synchronous read.
REQ-007 out_valid  out  1  result valid; pixel_on  out  1  final foreground decision; color  out  COLOR_W  colour index to DAC/palette.

Function
REQ-008 SHALL be a 3-stage pipeline: request sampled at edge N, result visible on outputs in cycle N+3; one request accepted per cycle, no stall.
REQ-009 Stage 1 SHALL register rom_addr = (chr_val-FIRST_CHR)*GLYPH_H + row, plus col, attr, cursor_hit, valid and an off flag.
REQ-010 off flag SHALL be set when chr_val<FIRST_CHR, chr_val>=FIRST_CHR+NUM_GLYPHS, col>=GLYPH_W or row>=GLYPH_H; when set, rom_addr SHALL be 0.
REQ-011 Stage 2 SHALL delay sideband to align with rom_q (ROM registers address at edge N+1, q valid in cycle N+2).
REQ-012 Stage 3 SHALL register glyph bit = rom_q[col] (bit 0 = leftmost column), forced 0 when off.
REQ-013 pixel_on SHALL equal glyph bit XOR (cursor_hit AND cursor_vis); color SHALL be fg when pixel_on else bg.
REQ-014 When stage-3 valid is 0: out_valid=0, pixel_on=0, color=0; in_valid=0 cycles propagate as bubbles.
REQ-015 Cursor blink counter SHALL increment on frame_tick; on reaching BLINK_DIV-1 with frame_tick it SHALL wrap to 0 and toggle cursor_vis.
REQ-016 cursor_vis change SHALL affect only requests sampled after the toggling edge; in-flight requests keep the value captured in stage 1.
REQ-017 frame_tick coincident with in_valid SHALL be handled independently; no request dropped.
REQ-018 Address arithmetic SHALL be done at ADDR_W bits, no wrap for in-range inputs.

Reset
REQ-019 rst held at an edge SHALL clear all pipeline valids, rom_addr=0, pixel_on=0, color=0, out_valid=0, blink counter=0, cursor_vis=1.
REQ-020 rst asserted mid-stream SHALL discard all in-flight requests; first request after rst deasserts appears 3 cycles after its sampling edge.
REQ-021 Inputs sampled on a cycle with rst high SHALL be ignored.

Configuration
REQ-022 Macro CHR_PIXEL_PIPE_CURSOR_BLINK_EN defined: blink counter and REQ-015/016 behaviour present.
REQ-023 Macro undefined: no blink counter, cursor_vis constant 1 (steady inverse cursor), frame_tick ignored, latency unchanged.

Verification
REQ-024 Defaults, chr_val=0x21, row=3, col=4, attr=0x1F, in_valid one cycle -> rom_addr=0x013 in N+1; rom_q=0x10 -> out_valid=1, pixel_on=1, color=0xF in N+3.
REQ-025 Same but rom_q=0x08 -> pixel_on=0, color=0x1; chr_val=0x1F or 0x80 -> rom_addr=0, pixel_on=0, color=bg regardless of rom_q.
REQ-026 Back-to-back 16 requests, col 0..7 twice, with one in_valid=0 gap -> 16 results in order, one out_valid=0 bubble at matching position.
REQ-027 With blink enabled, cursor_hit=1, rom_q=0: 31 frame_ticks -> pixel_on=1; 32nd tick -> later requests pixel_on=0; in-flight requests unaffected; without macro -> always pixel_on=1.
REQ-028 rst pulsed with 3 requests in flight -> no out_valid for them; blink counter 0, cursor_vis=1; next request output 3 cycles after sampling.
REQ-029 Parameter sweep GLYPH_W=6, GLYPH_H=12, NUM_GLYPHS=128 -> rom_addr=(chr_val-32)*12+row, col>=6 and row>=12 give pixel_on=0.

Source files
------------

// File: rtl/chr_pixel_pipe.sv
// chr_pixel_pipe: 3-stage text-mode pixel pipeline (glyph address, ROM alignment, glyph/cursor/colour).
// Define CHR_PIXEL_PIPE_CURSOR_BLINK_EN to add the frame_tick-driven blinking cursor.
module chr_pixel_pipe #(
  parameter int GLYPH_W    = 8,
  parameter int GLYPH_H    = 16,
  parameter int FIRST_CHR  = 32,
  parameter int NUM_GLYPHS = 96,
  parameter int COLOR_W    = 4,
  parameter int BLINK_DIV  = 32,
  localparam int COL_W     = $clog2(GLYPH_W),
  localparam int ROW_W     = $clog2(GLYPH_H),
  localparam int ADDR_W    = $clog2(NUM_GLYPHS * GLYPH_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           chr_val,
  input  logic [2*COLOR_W-1:0] attr,
  input  logic [COL_W-1:0]     col,
  input  logic [ROW_W-1:0]     row,
  input  logic                 cursor_hit,
  input  logic                 frame_tick,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [GLYPH_W-1:0]   rom_q,
  output logic                 out_valid,
  output logic                 pixel_on,
  output logic [COLOR_W-1:0]   color
);

  logic                 cursor_vis_s;
  logic [9:0]           chr_ext_s;
  logic                 off_s;
  logic [ADDR_W-1:0]    glyph_addr_s;
  logic [GLYPH_W-1:0]   glyph_shift_s;
  logic                 glyph_bit_s;
  logic                 pix_s;

  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic [COL_W-1:0]     col1_q, col2_q;
  logic [2*COLOR_W-1:0] attr1_q, attr2_q;
  logic                 cur1_q, cur1_d, cur2_q;
  logic                 v1_q, v2_q, off1_q, off2_q;
  logic                 out_valid_q, out_valid_d, pixel_on_q, pixel_on_d;
  logic [COLOR_W-1:0]   color_q, color_d;

`ifdef CHR_PIXEL_PIPE_CURSOR_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_DIV + 1);
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               cursor_vis_q, cursor_vis_d;

  // Blink counter next state: wrap at BLINK_DIV-1 and flip cursor visibility.
  always_comb begin
    blink_cnt_d  = blink_cnt_q;
    cursor_vis_d = cursor_vis_q;
    if (frame_tick) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d  = {BLINK_W{1'b0}};
        cursor_vis_d = ~cursor_vis_q;
      end else begin
        blink_cnt_d  = blink_cnt_q + {{(BLINK_W-1){1'b0}}, 1'b1};
      end
    end else begin
      blink_cnt_d  = blink_cnt_q;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q  <= {BLINK_W{1'b0}};
      cursor_vis_q <= 1'b1;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      cursor_vis_q <= cursor_vis_d;
    end
  end

  assign cursor_vis_s = cursor_vis_q;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = frame_tick ^ (BLINK_DIV > 0);
  assign cursor_vis_s = 1'b1;
`endif

  // Stage 1 decode: out-of-range codes or coordinates fetch address 0 and blank the pixel.
  always_comb begin
    chr_ext_s    = {2'b00, chr_val};
    off_s        = (chr_ext_s < 10'(FIRST_CHR)) ||
                   (chr_ext_s >= 10'(FIRST_CHR + NUM_GLYPHS)) ||
                   ({1'b0, col} >= (COL_W+1)'(GLYPH_W)) ||
                   ({1'b0, row} >= (ROW_W+1)'(GLYPH_H));
    glyph_addr_s = (ADDR_W'(chr_val) - ADDR_W'(FIRST_CHR)) * ADDR_W'(GLYPH_H) + ADDR_W'(row);
    if (off_s) begin
      rom_addr_d = {ADDR_W{1'b0}};
    end else begin
      rom_addr_d = glyph_addr_s;
    end
    cur1_d = cursor_hit & cursor_vis_s;
  end

  // Stage 3 decode: column select (bit 0 is leftmost), cursor inversion, palette pick.
  always_comb begin
    glyph_shift_s = rom_q >> col2_q;
    if (off2_q) begin
      glyph_bit_s = 1'b0;
    end else begin
      glyph_bit_s = glyph_shift_s[0];
    end
    pix_s       = glyph_bit_s ^ cur2_q;
    out_valid_d = v2_q;
    if (v2_q) begin
      pixel_on_d = pix_s;
      color_d    = pix_s ? attr2_q[COLOR_W-1:0] : attr2_q[2*COLOR_W-1:COLOR_W];
    end else begin
      pixel_on_d = 1'b0;
      color_d    = {COLOR_W{1'b0}};
    end
  end

  // Pipeline registers for all three stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q  <= {ADDR_W{1'b0}};
      col1_q      <= {COL_W{1'b0}};
      attr1_q     <= {(2*COLOR_W){1'b0}};
      cur1_q      <= 1'b0;
      v1_q        <= 1'b0;
      off1_q      <= 1'b0;
      col2_q      <= {COL_W{1'b0}};
      attr2_q     <= {(2*COLOR_W){1'b0}};
      cur2_q      <= 1'b0;
      v2_q        <= 1'b0;
      off2_q      <= 1'b0;
      out_valid_q <= 1'b0;
      pixel_on_q  <= 1'b0;
      color_q     <= {COLOR_W{1'b0}};
    end else begin
      rom_addr_q  <= rom_addr_d;
      col1_q      <= col;
      attr1_q     <= attr;
      cur1_q      <= cur1_d;
      v1_q        <= in_valid;
      off1_q      <= off_s;
      col2_q      <= col1_q;
      attr2_q     <= attr1_q;
      cur2_q      <= cur1_q;
      v2_q        <= v1_q;
      off2_q      <= off1_q;
      out_valid_q <= out_valid_d;
      pixel_on_q  <= pixel_on_d;
      color_q     <= color_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign pixel_on  = pixel_on_q;
  assign color     = color_q;

endmodule

// File: tb/tb_chr_pixel_pipe.sv
// Scoreboard bench for chr_pixel_pipe: default instance plus a 6x12/128-glyph instance.
// Expectations follow CHR_PIXEL_PIPE_CURSOR_BLINK_EN when it is defined.
module tb_chr_pixel_pipe;

`ifdef CHR_PIXEL_PIPE_CURSOR_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, frame_tick;
  logic        in_valid, cursor_hit, out_valid, pixel_on;
  logic [7:0]  chr_val, attr, rom_q;
  logic [2:0]  col;
  logic [3:0]  row, color;
  logic [10:0] rom_addr;
  logic        in_valid6, out_valid6, pixel_on6;
  logic [7:0]  chr6, attr6;
  logic [2:0]  col6;
  logic [3:0]  row6, color6;
  logic [10:0] rom_addr6;
  logic [5:0]  rom_q6;

  logic [7:0]  mem  [0:2047];
  logic [5:0]  mem6 [0:2047];

  typedef struct packed {
    logic        pix;
    logic [3:0]  col;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp6_q[$];
  exp_t em, em6;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic        pend_chk = 1'b0, pend6_chk = 1'b0;
  logic [10:0] pend_addr = 11'd0, pend6_addr = 11'd0;
  logic [7:0]  pat;

  chr_pixel_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .chr_val(chr_val), .attr(attr),
    .col(col), .row(row), .cursor_hit(cursor_hit), .frame_tick(frame_tick),
    .rom_addr(rom_addr), .rom_q(rom_q), .out_valid(out_valid), .pixel_on(pixel_on), .color(color)
  );

  chr_pixel_pipe #(.GLYPH_W(6), .GLYPH_H(12), .NUM_GLYPHS(128)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .chr_val(chr6), .attr(attr6),
    .col(col6), .row(row6), .cursor_hit(1'b0), .frame_tick(frame_tick),
    .rom_addr(rom_addr6), .rom_q(rom_q6), .out_valid(out_valid6), .pixel_on(pixel_on6), .color(color6)
  );

  always #5 clk = ~clk;

  // Synchronous glyph ROMs: address registered on the edge, data valid the following cycle.
  always @(posedge clk) begin
    rom_q  <= mem[rom_addr];
    rom_q6 <= mem6[rom_addr6];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ch, input logic [3:0] r, input logic [2:0] c,
                       input logic [7:0] a, input logic cur, input logic tk, input logic rs,
                       input logic push, input logic [10:0] eaddr, input logic epix, input logic [3:0] ecol);
    exp_t e;
    @(posedge clk); #1;
    if (pend_chk) chk("rom_addr", 32'(rom_addr), 32'(pend_addr));
    in_valid = v; chr_val = ch; row = r; col = c; attr = a; cursor_hit = cur;
    frame_tick = tk; rst = rs; in_valid6 = 1'b0; pend6_chk = 1'b0;
    pend_chk = v | rs; pend_addr = eaddr;
    if (push) begin
      e.pix = epix; e.col = ecol; e.cyc = 32'(cyc + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive6(input logic v, input logic [7:0] ch, input logic [3:0] r, input logic [2:0] c,
                        input logic [10:0] eaddr, input logic epix, input logic [3:0] ecol);
    exp_t e;
    @(posedge clk); #1;
    if (pend6_chk) chk("sweep_rom_addr", 32'(rom_addr6), 32'(pend6_addr));
    in_valid6 = v; chr6 = ch; row6 = r; col6 = c; attr6 = 8'h5A;
    in_valid = 1'b0; frame_tick = 1'b0; rst = 1'b0; pend_chk = 1'b0;
    pend6_chk = v; pend6_addr = eaddr;
    if (v) begin
      e.pix = epix; e.col = ecol; e.cyc = 32'(cyc + 1);
      exp6_q.push_back(e);
    end
  endtask

  task automatic idle(input logic tk);
    drive(1'b0, 8'h00, 4'd0, 3'd0, 8'h00, 1'b0, tk, 1'b0, 1'b0, 11'd0, 1'b0, 4'h0);
  endtask

  // Default-instance monitor: results must appear exactly two edges after their sampling edge.
  initial forever begin
    @(negedge clk);
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out actual=pixel_on %0b color %0h required=no output", pixel_on, color);
      end else begin
        em = exp_q.pop_front();
        chk("out_cycle", 32'(cyc), em.cyc + 32'd2);
        chk("pixel_on", 32'(pixel_on), 32'(em.pix));
        chk("color", 32'(color), 32'(em.col));
      end
    end else begin
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_outputs", {27'd0, pixel_on, color}, 32'd0);
    end
  end

  // Swept-instance monitor.
  initial forever begin
    @(negedge clk);
    if (out_valid6 === 1'b1) begin
      if (exp6_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sweep_unexpected_out actual=pixel_on %0b color %0h required=no output", pixel_on6, color6);
      end else begin
        em6 = exp6_q.pop_front();
        chk("sweep_out_cycle", 32'(cyc), em6.cyc + 32'd2);
        chk("sweep_pixel_on", 32'(pixel_on6), 32'(em6.pix));
        chk("sweep_color", 32'(color6), 32'(em6.col));
      end
    end else begin
      chk("sweep_idle", {26'd0, out_valid6, pixel_on6, color6}, 32'd0);
    end
  end

  initial begin
    rst = 1'b1; frame_tick = 1'b0; in_valid = 1'b0; cursor_hit = 1'b0;
    chr_val = 8'h00; attr = 8'h00; col = 3'd0; row = 4'd0;
    in_valid6 = 1'b0; chr6 = 8'h00; attr6 = 8'h00; col6 = 3'd0; row6 = 4'd0;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'h00;
      mem6[i] = 6'h00;
    end
    mem[11'h000] = 8'hFF; mem[11'h013] = 8'h10; mem[11'h023] = 8'h08;
    mem[11'h5FF] = 8'hFF; mem[11'h215] = 8'hA5;
    mem6[11'h000] = 6'h3F; mem6[11'h197] = 6'h20; mem6[11'h196] = 6'h3F;
    mem6[11'h198] = 6'h3F; mem6[11'h5F4] = 6'h01;
    pat = 8'hA5;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_sweep_rom_addr", 32'(rom_addr6), 32'd0);

    // Basic glyph lookups, out-of-range codes, first/last glyph, cursor inversion.
    drive(1'b1, 8'h21, 4'd3,  3'd4, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 11'h013, 1'b1, 4'hF);
    drive(1'b1, 8'h22, 4'd3,  3'd4, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 11'h023, 1'b0, 4'h1);
    drive(1'b1, 8'h1F, 4'd3,  3'd4, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 1'b0, 4'h1);
    drive(1'b1, 8'h80, 4'd3,  3'd4, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 1'b0, 4'h1);
    drive(1'b1, 8'h7F, 4'd15, 3'd0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 11'h5FF, 1'b1, 4'hF);
    drive(1'b1, 8'h20, 4'd0,  3'd0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000, 1'b1, 4'hF);
    drive(1'b1, 8'h21, 4'd3,  3'd4, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b1, 11'h013, 1'b0, 4'h1);
    idle(1'b0);

    // Back-to-back stream of 16 columns with one bubble.
    for (int k = 0; k < 16; k++) begin
      if (k == 5) idle(1'b0);
      drive(1'b1, 8'h41, 4'd5, 3'(k % 8), 8'h2C, 1'b0, 1'b0, 1'b0, 1'b1, 11'h215,
            pat[k % 8], pat[k % 8] ? 4'hC : 4'h2);
    end
    idle(1'b0);

    // Cursor blink: 31 ticks keep it visible; the 32nd affects only later requests.
    repeat (31) idle(1'b1);
    drive(1'b1, 8'h30, 4'd0, 3'd0, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b1, 11'h100, 1'b1, 4'hF);
    drive(1'b1, 8'h30, 4'd0, 3'd0, 8'h1F, 1'b1, 1'b1, 1'b0, 1'b1, 11'h100, 1'b1, 4'hF);
    drive(1'b1, 8'h30, 4'd0, 3'd0, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b1, 11'h100, ~BLINK, BLINK ? 4'h1 : 4'hF);
    drive(1'b1, 8'h30, 4'd0, 3'd0, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 11'h100, 1'b0, 4'h1);
    repeat (5) idle(1'b1);

    // Mid-stream reset: in-flight and rst-cycle requests vanish; state returns to reset values.
    drive(1'b1, 8'h21, 4'd3, 3'd4, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 11'h013, 1'b0, 4'h0);
    drive(1'b1, 8'h22, 4'd3, 3'd4, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 11'h023, 1'b0, 4'h0);
    drive(1'b1, 8'h21, 4'd3, 3'd4, 8'h1F, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 4'h0);
    drive(1'b1, 8'h21, 4'd3, 3'd4, 8'h1F, 1'b0, 1'b0, 1'b0, 1'b1, 11'h013, 1'b1, 4'hF);
    repeat (3) idle(1'b0);
    repeat (31) idle(1'b1);
    drive(1'b1, 8'h30, 4'd0, 3'd0, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b1, 11'h100, 1'b1, 4'hF);
    idle(1'b1);
    drive(1'b1, 8'h30, 4'd0, 3'd0, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b1, 11'h100, ~BLINK, BLINK ? 4'h1 : 4'hF);
    idle(1'b0);

    // Swept geometry: 6-wide, 12-high glyphs, 128 glyphs.
    drive6(1'b1, 8'h41, 4'd11, 3'd5, 11'h197, 1'b1, 4'hA);
    drive6(1'b1, 8'h41, 4'd11, 3'd4, 11'h197, 1'b0, 4'h5);
    drive6(1'b1, 8'h41, 4'd10, 3'd6, 11'h000, 1'b0, 4'h5);
    drive6(1'b1, 8'h41, 4'd12, 3'd0, 11'h000, 1'b0, 4'h5);
    drive6(1'b1, 8'h9F, 4'd0,  3'd0, 11'h5F4, 1'b1, 4'hA);
    drive6(1'b1, 8'hA0, 4'd0,  3'd0, 11'h000, 1'b0, 4'h5);
    drive6(1'b1, 8'h20, 4'd0,  3'd0, 11'h000, 1'b1, 4'hA);
    drive6(1'b0, 8'h00, 4'd0,  3'd0, 11'h000, 1'b0, 4'h0);

    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("sweep_queue_drained", 32'(exp6_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
